// File: rtl/pocket_pkg.sv
// Shared bridge types used by the host-side bridge and the blocks hanging off it.
package pocket;
  typedef logic [31:0] bridge_addr_t;
endpackage

// File: rtl/bridge_if.sv
// Same-clock host bridge bundle: one-cycle write/read strobes, read data returned by the target.
interface bridge_if;
  pocket::bridge_addr_t addr;
  logic                 wr;
  logic                 rd;
  logic [31:0]          wr_data;
  logic [31:0]          rd_data;

  modport target (input addr, wr, rd, wr_data, output rd_data);
  modport host   (output addr, wr, rd, wr_data, input rd_data);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word-fall-through head; write-to-head latency 1 cycle.
// A push while full is dropped; a same-cycle pop never makes room for that push.
module sync_fifo #(
  parameter int address_width = 2,
  parameter int data_width    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd,
  output logic [data_width-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);
  localparam int depth = 1 << address_width;

  logic [data_width-1:0]    mem [depth];
  logic [address_width-1:0] wr_ptr;
  logic [address_width-1:0] rd_ptr;
  logic [address_width:0]   count;
  logic                     push;
  logic                     pop;

  assign empty   = (count == '0);
  assign full    = (count == (address_width + 1)'(depth));
  assign push    = wr && !full;
  assign pop     = rd && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + address_width'(1);
      if (pop)  rd_ptr <= rd_ptr + address_width'(1);
      if (push && !pop)      count <= count + (address_width + 1)'(1);
      else if (!push && pop) count <= count - (address_width + 1)'(1);
    end
  end
endmodule

// File: rtl/bridge_queue.sv
// Buffers host bridge requests and replays them one at a time to a slow target, one read in flight.
// Request visible downstream 1 cycle after enqueue; out_ready stalls the head, drops only when full.
module bridge_queue
  import pocket::*;
#(
  parameter int                    address_width = 2,
  parameter int                    data_width    = 32,
  parameter int                    rd_timeout    = 255,
  parameter logic [data_width-1:0] timeout_data  = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  bridge_if.target              in,
  output bridge_addr_t          out_addr,
  output logic [data_width-1:0] out_wr_data,
  output logic                  out_wr,
  output logic                  out_rd,
  input  logic                  out_ready,
  input  logic                  out_rd_valid,
  input  logic [data_width-1:0] out_rd_data,
  output logic                  full,
  output logic                  overflow,
  output logic [15:0]           overflow_count,
  output logic [15:0]           timeout_count
);
  localparam int tw = $clog2(rd_timeout + 1);

  typedef struct packed {
    bridge_addr_t          addr;
    logic [data_width-1:0] wr_data;
    logic                  wr;
  } entry_t;

  typedef enum logic {ISSUE, WAIT_RD} state_t;

  state_t                state;
  logic [tw-1:0]         timer;
  logic [data_width-1:0] rd_data_q;
  entry_t                push_entry;
  entry_t                head;
  logic                  push_req;
  logic                  fifo_empty;
  logic                  issue_vld;
  logic                  pop;

  assign push_req   = in.wr || in.rd;
  assign push_entry = '{addr: in.addr, wr_data: in.wr_data, wr: in.wr};

  sync_fifo #(
    .address_width (address_width),
    .data_width    ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (push_req),
    .wr_data (push_entry),
    .rd      (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (full)
  );

  assign issue_vld   = (state == ISSUE) && !fifo_empty;
  assign out_wr      = issue_vld && head.wr;
  assign out_rd      = issue_vld && !head.wr;
  assign pop         = issue_vld && out_ready;
  assign out_addr    = fifo_empty ? '0 : head.addr;
  assign out_wr_data = fifo_empty ? '0 : head.wr_data;
  assign in.rd_data  = rd_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ISSUE;
      timer          <= '0;
      rd_data_q      <= '0;
      timeout_count  <= '0;
      overflow       <= 1'b0;
      overflow_count <= '0;
    end else begin
      case (state)
        ISSUE: begin
          if (pop && !head.wr) begin
            state <= WAIT_RD;
            timer <= tw'(rd_timeout);
          end
        end
        WAIT_RD: begin
          // A response in the final timer cycle still beats the timeout.
          if (out_rd_valid) begin
            rd_data_q <= out_rd_data;
            state     <= ISSUE;
          end else if (timer == tw'(1)) begin
            rd_data_q <= timeout_data;
            state     <= ISSUE;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          end else begin
            timer <= timer - tw'(1);
          end
        end
        default: state <= ISSUE;
      endcase

      if (push_req && full) begin
        overflow <= 1'b1;
        if (overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
      end
    end
  end
endmodule

// File: doc/bridge_queue.md
# bridge_queue

Single-clock, parametrised request queue between a host-facing `bridge_if` target and a downstream register target that can stall and answer reads late. Host writes and reads are buffered in a depth-configurable FIFO and replayed to the target one at a time, with a ready handshake and at most one read in flight. Read data comes back through a timeout-protected capture register. The block replaces ad-hoc same-clock bridge plumbing where the target is slower than the bridge and cannot accept a request every cycle.

## Interface
- `address_width`, 2: FIFO depth = 2**address_width entries.
- `data_width`, 32: width of wr_data/rd_data; must equal `$bits(in.wr_data)`.
- `rd_timeout`, 255: cycles to wait for `out_rd_valid` before abandoning a read; ≥ 1.
- `timeout_data`, 32'hDEAD_BEEF: value returned on `in.rd_data` after a read timeout.

- `clk` in 1: single clock; `in` is also clocked by `clk`.
- `reset` in 1: synchronous, active-high.
- `in` bridge_if (target side): addr, wr, rd, wr_data in; rd_data out.
- `out_addr` out 32: head-entry address (pocket::bridge_addr_t).
- `out_wr_data` out data_width: head-entry write data.
- `out_wr` out 1: write request valid.
- `out_rd` out 1: read request valid.
- `out_ready` in 1: target accepts the current request this cycle.
- `out_rd_valid` in 1: read data valid, one-cycle pulse.
- `out_rd_data` in data_width: read data, sampled when `out_rd_valid` is high.
- `full` out 1: queue holds 2**address_width entries.
- `overflow` out 1: sticky; a request has been dropped since reset.
- `overflow_count` out 16: saturating count of dropped requests.
- `timeout_count` out 16: saturating count of read timeouts.

## Operation
- Push: every cycle with `in.wr || in.rd`, enqueue {addr, wr_data, wr=in.wr}. If `wr` and `rd` are both high, the entry is a write.
- Push succeeds iff occupancy is below depth at the start of the cycle. A same-cycle pop does not free a slot for that push. A dropped push sets `overflow` and increments `overflow_count`, saturating at 16'hFFFF.
- FSM states:
  - ISSUE (reset state):
    - If the queue is non-empty, drive the head: `out_wr` = head.wr, `out_rd` = !head.wr.
    - Write with `out_ready`: pop, stay in ISSUE.
    - Read with `out_ready`: pop, go to WAIT_RD, load timer with `rd_timeout`.
  - WAIT_RD:
    - `out_wr` and `out_rd` are 0.
    - On `out_rd_valid`: register `out_rd_data` into `in.rd_data`, go to ISSUE.
    - Otherwise the timer decrements. At zero: `in.rd_data` ← `timeout_data`, increment `timeout_count` (saturating), go to ISSUE.
- `out_rd_valid` in ISSUE is ignored; `in.rd_data` does not change.
- `in.rd_data` holds its last value until the next read completes or times out.
- `out_addr` and `out_wr_data` show the head entry whenever the queue is non-empty. When empty they are don't-care; the implementation drives 0.
- Reset, including mid-read:
  - Queue is emptied and the FSM returns to ISSUE.
  - `in.rd_data`, counters, `overflow` and `full` go to 0.
  - An in-flight read response arriving after reset is ignored.

## Timing
- Reset values: all outputs 0.
- Enqueue-to-issue latency: 1 cycle. A request on `in` at cycle N is visible on `out_*` at cycle N+1 when the queue is empty and the FSM is in ISSUE.
- Writes: back-to-back throughput of 1 per cycle while `out_ready` = 1.
- Read completion: `out_rd_valid` at cycle K → `in.rd_data` updated at K+1. The next request can issue at K+1.
- A response on the same cycle the timer reaches zero: the valid response wins and the timeout is not counted.
- Timeout: with no response, `in.rd_data` = `timeout_data` exactly `rd_timeout`+1 cycles after the read is accepted.
- `full` is registered: it reflects occupancy after the current cycle's push and pop.

## Structure
- Address type is `pocket::bridge_addr_t`. `bridge_queue` adds no new package types.
- The entry struct {addr, wr_data, wr} is a module-local typedef, because its width depends on `data_width`.
- Sub-module `sync_fifo`, parameters (`address_width`, `data_width`):
  - Ports: clk, reset, wr, wr_data, rd, rd_data, empty, full.
  - Registered storage, first-word-fall-through head.
  - Reusable by other single-clock blocks.

## Test plan
- Single write: `in.wr`, addr 0x10, data 0x1234, `out_ready`=1 → `out_wr`=1 one cycle later with addr 0x10, data 0x1234; then queue empty.
- Read latency: read of 0x20, target answers 5 cycles after accept with 0xCAFE → `in.rd_data`=0xCAFE on the next cycle; no request issued while waiting.
- Backpressure and overflow (address_width=2): `out_ready`=0, issue 6 writes → `full`=1, `overflow`=1, `overflow_count`=2. Release `out_ready` → exactly the first 4 writes emerge in order.
- Timeout (rd_timeout=8): read accepted, no response → `in.rd_data`=32'hDEADBEEF at cycle 9 after accept, `timeout_count`=1. A late `out_rd_valid` does not change `in.rd_data`.
- Ordering: write A, read B, write C queued with the target answering in 2 cycles → C not issued until B completes. Sequence on `out` is A, B, C.
- Reset mid-read: assert `reset` in WAIT_RD → next cycle all outputs 0. A subsequent `out_rd_valid` with 0x5555 leaves `in.rd_data`=0.
